// File: rtl/console_writer_if.sv
// Bundles the byte-stream handshake and the char-buffer/cursor write bus
// of the console writer. The "master" side is the writer itself, which drives
// buffer, scroll and cursor updates. The "slave" side is the environment, which
// supplies bytes and consumes those updates.
interface console_writer_if #(
    parameter int ADDR_BITS = 11,
    parameter int COL_BITS  = 7,
    parameter int ROW_BITS  = 5
);
    logic [7:0]           data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic [ADDR_BITS-1:0] buffer_waddr;
    logic [7:0]           buffer_din;
    logic                 buffer_wen;
    logic [ADDR_BITS-1:0] buffer_first_char;
    logic                 buffer_first_char_wen;
    logic [COL_BITS-1:0]  new_cursor_x;
    logic [ROW_BITS-1:0]  new_cursor_y;
    logic                 new_cursor_wen;

    modport master (
        input  data_in, data_valid,
        output data_ready,
        output buffer_waddr, buffer_din, buffer_wen,
        output buffer_first_char, buffer_first_char_wen,
        output new_cursor_x, new_cursor_y, new_cursor_wen
    );

    modport slave (
        output data_in, data_valid,
        input  data_ready,
        input  buffer_waddr, buffer_din, buffer_wen,
        input  buffer_first_char, buffer_first_char_wen,
        input  new_cursor_x, new_cursor_y, new_cursor_wen
    );
endinterface

// File: rtl/console_writer.sv
// Writer side of the 80x24 text console. It turns a byte stream into
// char-buffer writes, cursor loads and scroll (first-char) loads. The buffer is
// circular, so scrolling only moves the first-char pointer and then blanks the
// row that becomes the new bottom line. Cell addresses are tracked through a
// running row-base register instead of multiplying y by COLS.
module console_writer #(
    parameter int ROWS          = 24,
    parameter int COLS          = 80,
    parameter int ROW_BITS      = 5,
    parameter int COL_BITS      = 7,
    parameter int ADDR_BITS     = 11,
    parameter int PAST_LAST_ROW = ROWS * COLS
) (
    input  logic            clk,
    input  logic            clr_n,
    console_writer_if.master bus
);

    localparam logic [COL_BITS-1:0]  LAST_COL      = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW      = ROW_BITS'(ROWS - 1);
    localparam logic [ADDR_BITS-1:0] COLS_A        = ADDR_BITS'(COLS);
    localparam logic [ADDR_BITS-1:0] LAST_CLEAR    = ADDR_BITS'(COLS - 1);
    localparam logic [ADDR_BITS-1:0] BUF_SIZE      = ADDR_BITS'(PAST_LAST_ROW);
    localparam logic [ADDR_BITS-1:0] LAST_ROW_BASE = ADDR_BITS'(PAST_LAST_ROW - COLS);
    localparam logic [7:0]           SPACE         = 8'h20;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_UPDATE,
        S_SCROLL,
        S_CLEAR
    } state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] count_q;
    logic [COL_BITS-1:0]  cursorX_q;
    logic [ROW_BITS-1:0]  cursorY_q;
    logic [ADDR_BITS-1:0] rowBase_q;
    logic [ADDR_BITS-1:0] firstChar_q;
    logic                 scrollPending_q;

    logic                 ready_q;
    logic [ADDR_BITS-1:0] waddr_q;
    logic [7:0]           din_q;
    logic                 wen_q;
    logic                 firstWen_q;
    logic [COL_BITS-1:0]  outX_q;
    logic [ROW_BITS-1:0]  outY_q;
    logic                 cursorWen_q;

    logic                 printable_d;
    logic                 moveCursor_d;
    logic                 newline_d;
    logic                 scroll_d;
    logic [COL_BITS-1:0]  nextX_d;
    logic [ROW_BITS-1:0]  nextY_d;
    logic [ADDR_BITS-1:0] nextRowBase_d;
    logic [ADDR_BITS-1:0] cellAddr_d;

    // Step a row-aligned address down one screen row, wrapping at the buffer end.
    function automatic logic [ADDR_BITS-1:0] rowAdvance(input logic [ADDR_BITS-1:0] base);
        return (base == LAST_ROW_BASE) ? '0 : base + COLS_A;
    endfunction

    // Decode the incoming byte into its cursor move, newline and scroll effects.
    always_comb begin
        printable_d  = (bus.data_in >= 8'h20) && (bus.data_in <= 8'h7E);
        moveCursor_d = 1'b0;
        newline_d    = 1'b0;
        nextX_d      = cursorX_q;
        if (printable_d) begin
            moveCursor_d = 1'b1;
            if (cursorX_q == LAST_COL) begin
                nextX_d   = '0;
                newline_d = 1'b1;
            end else begin
                nextX_d = cursorX_q + 1'b1;
            end
        end else begin
            case (bus.data_in)
                8'h0D: begin
                    moveCursor_d = 1'b1;
                    nextX_d      = '0;
                end
                8'h08: begin
                    moveCursor_d = 1'b1;
                    if (cursorX_q != '0) begin
                        nextX_d = cursorX_q - 1'b1;
                    end
                end
                8'h0A: begin
                    moveCursor_d = 1'b1;
                    newline_d    = 1'b1;
                end
                default: begin
                    moveCursor_d = 1'b0;
                end
            endcase
        end
        scroll_d      = newline_d && (cursorY_q == LAST_ROW);
        nextY_d       = (newline_d && !scroll_d) ? cursorY_q + 1'b1 : cursorY_q;
        nextRowBase_d = (newline_d && !scroll_d) ? rowAdvance(rowBase_q) : rowBase_q;
        cellAddr_d    = rowBase_q + ADDR_BITS'(cursorX_q);
    end

    // Main FSM: blank the screen, accept bytes, apply them, then scroll and clear when needed.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q         <= S_INIT;
            count_q         <= '0;
            cursorX_q       <= '0;
            cursorY_q       <= '0;
            rowBase_q       <= '0;
            firstChar_q     <= '0;
            scrollPending_q <= 1'b0;
            ready_q         <= 1'b0;
            waddr_q         <= '0;
            din_q           <= '0;
            wen_q           <= 1'b0;
            firstWen_q      <= 1'b0;
            outX_q          <= '0;
            outY_q          <= '0;
            cursorWen_q     <= 1'b0;
        end else begin
            wen_q       <= 1'b0;
            firstWen_q  <= 1'b0;
            cursorWen_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (count_q == BUF_SIZE) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wen_q   <= 1'b1;
                        waddr_q <= count_q;
                        din_q   <= SPACE;
                        count_q <= count_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.data_valid && ready_q) begin
                        ready_q         <= 1'b0;
                        state_q         <= S_UPDATE;
                        cursorX_q       <= nextX_d;
                        cursorY_q       <= nextY_d;
                        rowBase_q       <= nextRowBase_d;
                        scrollPending_q <= scroll_d;
                        if (printable_d) begin
                            wen_q   <= 1'b1;
                            waddr_q <= cellAddr_d;
                            din_q   <= bus.data_in;
                        end
                        if (moveCursor_d && !scroll_d) begin
                            cursorWen_q <= 1'b1;
                            outX_q      <= nextX_d;
                            outY_q      <= nextY_d;
                        end
                    end
                end
                S_UPDATE: begin
                    if (scrollPending_q) begin
                        state_q     <= S_SCROLL;
                        firstWen_q  <= 1'b1;
                        firstChar_q <= rowAdvance(firstChar_q);
                        rowBase_q   <= firstChar_q;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_SCROLL: begin
                    state_q         <= S_CLEAR;
                    scrollPending_q <= 1'b0;
                    wen_q           <= 1'b1;
                    waddr_q         <= rowBase_q;
                    din_q           <= SPACE;
                    count_q         <= ADDR_BITS'(1);
                end
                S_CLEAR: begin
                    if (count_q == COLS_A) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        wen_q   <= 1'b1;
                        waddr_q <= rowBase_q + count_q;
                        din_q   <= SPACE;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_CLEAR) begin
                            cursorWen_q <= 1'b1;
                            outX_q      <= cursorX_q;
                            outY_q      <= cursorY_q;
                        end
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.data_ready            = ready_q;
    assign bus.buffer_waddr          = waddr_q;
    assign bus.buffer_din            = din_q;
    assign bus.buffer_wen            = wen_q;
    assign bus.buffer_first_char     = firstChar_q;
    assign bus.buffer_first_char_wen = firstWen_q;
    assign bus.new_cursor_x          = outX_q;
    assign bus.new_cursor_y          = outY_q;
    assign bus.new_cursor_wen        = cursorWen_q;

endmodule
